// File: rtl/dispatch_router.sv
// Dispatch router: one holding register steers renamed instructions to ALU/LSU/BR/OTHER
// destinations, gated by per-station credit counters, with a saturating stall counter.
module dispatch_router #(
    parameter int unsigned DATA_W   = 128,
    parameter int unsigned ALU_CRED = 8,
    parameter int unsigned LSU_CRED = 8,
    parameter int unsigned BR_CRED  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_fu,
    input  logic [DATA_W-1:0] in_data,
    output logic              alu_valid,
    output logic              lsu_valid,
    output logic              br_valid,
    output logic              other_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              alu_cred_ret,
    input  logic              lsu_cred_ret,
    input  logic              br_cred_ret,
    output logic [15:0]       stall_cnt
);

    localparam int unsigned ALU_W = $clog2(ALU_CRED + 1);
    localparam int unsigned LSU_W = $clog2(LSU_CRED + 1);
    localparam int unsigned BR_W  = $clog2(BR_CRED + 1);

    localparam logic [ALU_W-1:0] ALU_MAX = ALU_W'(ALU_CRED);
    localparam logic [LSU_W-1:0] LSU_MAX = LSU_W'(LSU_CRED);
    localparam logic [BR_W-1:0]  BR_MAX  = BR_W'(BR_CRED);
    localparam logic [ALU_W-1:0] ALU_ONE = ALU_W'(1);
    localparam logic [LSU_W-1:0] LSU_ONE = LSU_W'(1);
    localparam logic [BR_W-1:0]  BR_ONE  = BR_W'(1);

    logic              r_hold_v;
    logic [1:0]        r_hold_fu;
    logic [DATA_W-1:0] r_hold_data;
    logic [ALU_W-1:0]  r_alu_c;
    logic [LSU_W-1:0]  r_lsu_c;
    logic [BR_W-1:0]   r_br_c;
    logic [15:0]       r_stall_cnt;

    logic              w_issue;
    logic              w_load;
    logic              w_hold_v_d;
    logic [ALU_W-1:0]  w_alu_c_d;
    logic [LSU_W-1:0]  w_lsu_c_d;
    logic [BR_W-1:0]   w_br_c_d;
    logic [15:0]       w_stall_d;

    // All strobes are masked by flush so nothing issues in the flush cycle.
    assign alu_valid   = r_hold_v & ~flush & (r_hold_fu == 2'd0) & (r_alu_c != '0);
    assign lsu_valid   = r_hold_v & ~flush & (r_hold_fu == 2'd1) & (r_lsu_c != '0);
    assign br_valid    = r_hold_v & ~flush & (r_hold_fu == 2'd2) & (r_br_c != '0);
    assign other_valid = r_hold_v & ~flush & (r_hold_fu == 2'd3);

    assign w_issue   = alu_valid | lsu_valid | br_valid | other_valid;
    // rst_n gates in_ready so it reads low while reset is held, independent of the clock.
    assign in_ready  = rst_n & ~flush & (~r_hold_v | w_issue);
    assign w_load    = in_valid & in_ready;
    assign out_data  = r_hold_data;
    assign stall_cnt = r_stall_cnt;

    always_comb begin
        w_hold_v_d = r_hold_v;
        if (flush) begin
            w_hold_v_d = 1'b0;
        end else if (w_load) begin
            w_hold_v_d = 1'b1;
        end else if (w_issue) begin
            w_hold_v_d = 1'b0;
        end
    end

    // Issue and return in the same cycle cancel; returns beyond max are dropped.
    always_comb begin
        w_alu_c_d = r_alu_c;
        if (flush) begin
            w_alu_c_d = ALU_MAX;
        end else if (alu_valid && !alu_cred_ret) begin
            w_alu_c_d = r_alu_c - ALU_ONE;
        end else if (!alu_valid && alu_cred_ret && (r_alu_c != ALU_MAX)) begin
            w_alu_c_d = r_alu_c + ALU_ONE;
        end
    end

    always_comb begin
        w_lsu_c_d = r_lsu_c;
        if (flush) begin
            w_lsu_c_d = LSU_MAX;
        end else if (lsu_valid && !lsu_cred_ret) begin
            w_lsu_c_d = r_lsu_c - LSU_ONE;
        end else if (!lsu_valid && lsu_cred_ret && (r_lsu_c != LSU_MAX)) begin
            w_lsu_c_d = r_lsu_c + LSU_ONE;
        end
    end

    always_comb begin
        w_br_c_d = r_br_c;
        if (flush) begin
            w_br_c_d = BR_MAX;
        end else if (br_valid && !br_cred_ret) begin
            w_br_c_d = r_br_c - BR_ONE;
        end else if (!br_valid && br_cred_ret && (r_br_c != BR_MAX)) begin
            w_br_c_d = r_br_c + BR_ONE;
        end
    end

    always_comb begin
        w_stall_d = r_stall_cnt;
        if (r_hold_v && !w_issue && !flush && (r_stall_cnt != 16'hFFFF)) begin
            w_stall_d = r_stall_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_v    <= 1'b0;
            r_hold_fu   <= 2'd0;
            r_alu_c     <= ALU_MAX;
            r_lsu_c     <= LSU_MAX;
            r_br_c      <= BR_MAX;
            r_stall_cnt <= 16'd0;
        end else begin
            r_hold_v    <= w_hold_v_d;
            r_alu_c     <= w_alu_c_d;
            r_lsu_c     <= w_lsu_c_d;
            r_br_c      <= w_br_c_d;
            r_stall_cnt <= w_stall_d;
            if (w_load) begin
                r_hold_fu <= in_fu;
            end
        end
    end

    // Payload needs no reset; it is only observed while r_hold_v is set.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_hold_data <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !flush) begin
            assert (!(alu_cred_ret && !alu_valid && (r_alu_c == ALU_MAX)))
                else $error("alu credit return beyond maximum");
            assert (!(lsu_cred_ret && !lsu_valid && (r_lsu_c == LSU_MAX)))
                else $error("lsu credit return beyond maximum");
            assert (!(br_cred_ret && !br_valid && (r_br_c == BR_MAX)))
                else $error("br credit return beyond maximum");
        end
    end

endmodule

// File: tb/tb_dispatch_router.sv
// Self-checking bench for dispatch_router: vector table, directed corner sequences and
// randomized traffic compared against a credit/slot reference model.
module tb_dispatch_router;

    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_fu;
    logic [DW-1:0] in_data;
    logic          alu_valid;
    logic          lsu_valid;
    logic          br_valid;
    logic          other_valid;
    logic [DW-1:0] out_data;
    logic          alu_cred_ret;
    logic          lsu_cred_ret;
    logic          br_cred_ret;
    logic [15:0]   stall_cnt;

    dispatch_router #(
        .DATA_W  (DW),
        .ALU_CRED(8),
        .LSU_CRED(8),
        .BR_CRED (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_fu       (in_fu),
        .in_data     (in_data),
        .alu_valid   (alu_valid),
        .lsu_valid   (lsu_valid),
        .br_valid    (br_valid),
        .other_valid (other_valid),
        .out_data    (out_data),
        .alu_cred_ret(alu_cred_ret),
        .lsu_cred_ret(lsu_cred_ret),
        .br_cred_ret (br_cred_ret),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: one optional slot, integer credit pools, stall counter.
    bit            m_hv;
    int            m_fu;
    logic [DW-1:0] m_data;
    int            m_cred[4];
    int            m_stall;
    int            cmax[4] = '{8, 8, 4, 0};

    logic [3:0]    last_obs;
    logic          last_rdy;
    logic [15:0]   last_stall;
    int            obs_cnt[4];

    typedef struct {
        logic        v;
        logic [1:0]  fu;
        logic [2:0]  ret;
        logic [3:0]  ev;
        logic        rdy;
        logic [15:0] st;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hv    = 1'b0;
        m_stall = 0;
        for (int k = 0; k < 4; k++) m_cred[k] = cmax[k];
    endtask

    task automatic clear_obs();
        for (int k = 0; k < 4; k++) obs_cnt[k] = 0;
    endtask

    // Called at posedge+1: drive, check mid-cycle against the model, advance at the edge.
    task automatic cycle(input logic v, input logic [1:0] fu, input logic [DW-1:0] d,
                         input logic [2:0] ret, input logic fl);
        logic [3:0] ev;
        bit         issue;
        bit         rdy;
        in_valid = v;
        in_fu    = fu;
        in_data  = d;
        {br_cred_ret, lsu_cred_ret, alu_cred_ret} = ret;
        flush    = fl;
        issue = m_hv && !fl && ((m_fu == 3) || (m_cred[m_fu] > 0));
        ev    = issue ? (4'b0001 << m_fu) : 4'b0000;
        rdy   = !fl && (!m_hv || issue);
        @(negedge clk);
        last_obs   = {other_valid, br_valid, lsu_valid, alu_valid};
        last_rdy   = in_ready;
        last_stall = stall_cnt;
        for (int k = 0; k < 4; k++) obs_cnt[k] += int'(last_obs[k]);
        chk("valid", 64'(last_obs), 64'(ev));
        chk("in_ready", 64'(in_ready), 64'(rdy));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        if (m_hv) chk("out_data", 64'(out_data), 64'(m_data));
        @(posedge clk);
        if (fl) begin
            m_hv = 1'b0;
            for (int k = 0; k < 3; k++) m_cred[k] = cmax[k];
        end else begin
            for (int k = 0; k < 3; k++)
                m_cred[k] += int'(ret[k]) - ((issue && m_fu == k) ? 1 : 0);
            if (m_hv && !issue && m_stall < 16'hFFFF) m_stall++;
            if (v && rdy) begin
                m_hv   = 1'b1;
                m_fu   = int'(fu);
                m_data = d;
            end else if (issue) begin
                m_hv = 1'b0;
            end
        end
        #1;
    endtask

    task automatic ops(input int fu, input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 2'(fu), DW'($urandom), 3'b000, 1'b0);
        cycle(1'b0, 2'(fu), '0, 3'b000, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        in_fu = 2'd0;
        in_data = '0;
        alu_cred_ret = 1'b0;
        lsu_cred_ret = 1'b0;
        br_cred_ret = 1'b0;
        clear_obs();
        model_reset();

        // Branch credit exhaustion: 4 issue, 5th stalls, one return releases it.
        tbl[0] = '{1'b1, 2'd2, 3'b000, 4'b0000, 1'b1, 16'd0};
        tbl[1] = '{1'b1, 2'd2, 3'b000, 4'b0100, 1'b1, 16'd0};
        tbl[2] = '{1'b1, 2'd2, 3'b000, 4'b0100, 1'b1, 16'd0};
        tbl[3] = '{1'b1, 2'd2, 3'b000, 4'b0100, 1'b1, 16'd0};
        tbl[4] = '{1'b1, 2'd2, 3'b000, 4'b0100, 1'b1, 16'd0};
        tbl[5] = '{1'b0, 2'd0, 3'b000, 4'b0000, 1'b0, 16'd0};
        tbl[6] = '{1'b0, 2'd0, 3'b000, 4'b0000, 1'b0, 16'd1};
        tbl[7] = '{1'b0, 2'd0, 3'b100, 4'b0000, 1'b0, 16'd2};
        tbl[8] = '{1'b0, 2'd0, 3'b000, 4'b0100, 1'b1, 16'd3};
        tbl[9] = '{1'b0, 2'd0, 3'b000, 4'b0000, 1'b1, 16'd3};

        #3;
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        chk("reset_valids", 64'({other_valid, br_valid, lsu_valid, alu_valid}), 64'd0);
        chk("reset_stall", 64'(stall_cnt), 64'd0);
        #9;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].v, tbl[i].fu, DW'(32'hB000 + i), tbl[i].ret, 1'b0);
            chk($sformatf("tbl%0d_valid", i), 64'(last_obs), 64'(tbl[i].ev));
            chk($sformatf("tbl%0d_ready", i), 64'(last_rdy), 64'(tbl[i].rdy));
            chk($sformatf("tbl%0d_stall", i), 64'(last_stall), 64'(tbl[i].st));
        end

        // Back-to-back ALU, then drain every pool and route an OTHER op.
        cycle(1'b0, 2'd0, '0, 3'b000, 1'b1);
        clear_obs();
        ops(0, 8);
        chk("b2b_alu_cnt", 64'(obs_cnt[0]), 64'd8);
        ops(1, 8);
        ops(2, 4);
        cycle(1'b1, 2'd3, DW'(32'h0DD0), 3'b000, 1'b0);
        cycle(1'b0, 2'd0, '0, 3'b000, 1'b0);
        chk("other_pulse", 64'(last_obs), 64'b1000);
        cycle(1'b1, 2'd0, DW'(32'hA1A1), 3'b000, 1'b0);
        cycle(1'b0, 2'd0, '0, 3'b000, 1'b0);
        chk("alu_blocked_at_zero", 64'(last_obs), 64'd0);
        cycle(1'b0, 2'd0, '0, 3'b000, 1'b0);

        // Asynchronous reset between edges while an op is stalled.
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_in_ready", 64'(in_ready), 64'd0);
        chk("async_valids", 64'({other_valid, br_valid, lsu_valid, alu_valid}), 64'd0);
        chk("async_stall", 64'(stall_cnt), 64'd0);
        #8;
        chk("async_held_stall", 64'(stall_cnt), 64'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;

        // Simultaneous issue and return with three ALU credits left.
        ops(0, 5);
        cycle(1'b1, 2'd0, DW'(32'h5151), 3'b000, 1'b0);
        cycle(1'b0, 2'd0, '0, 3'b001, 1'b0);
        chk("simul_issue", 64'(last_obs), 64'b0001);
        clear_obs();
        ops(0, 4);
        chk("alu_simul_cnt", 64'(obs_cnt[0]), 64'd3);

        // Flush while an LSU op is blocked on zero credit.
        cycle(1'b0, 2'd0, '0, 3'b000, 1'b1);
        ops(1, 9);
        cycle(1'b0, 2'd0, '0, 3'b000, 1'b1);
        chk("flush_no_lsu", 64'(last_obs), 64'd0);
        chk("flush_ready_low", 64'(last_rdy), 64'd0);
        cycle(1'b0, 2'd0, '0, 3'b000, 1'b0);
        chk("flush_clears_hold", 64'(last_obs), 64'd0);
        chk("ready_after_flush", 64'(last_rdy), 64'd1);
        clear_obs();
        ops(1, 8);
        chk("lsu_after_flush_cnt", 64'(obs_cnt[1]), 64'd8);

        // Randomized traffic; returns only while a pool is below its maximum.
        for (int n = 0; n < 3000; n++) begin
            logic [2:0] ret;
            for (int k = 0; k < 3; k++)
                ret[k] = ($urandom_range(3) == 0) && (m_cred[k] < cmax[k]);
            cycle(1'($urandom_range(3) != 0), 2'($urandom_range(3)), DW'($urandom), ret,
                  1'($urandom_range(49) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dispatch_router.md
DISPATCH_ROUTER -- requirements
Module: dispatch_router

Interface
REQ-001 SHALL have parameter DATA_W, default 128, meaning width of the renamed-instruction payload carried opaquely.
REQ-002 SHALL have parameter ALU_CRED, default 8, meaning ALU reservation-station entries.
REQ-003 SHALL have parameter LSU_CRED, default 8, meaning LSU reservation-station entries.
REQ-004 SHALL have parameter BR_CRED, default 4, meaning branch reservation-station entries.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-007 SHALL have port flush, input, 1, meaning pipeline flush (mispredict/exception).
REQ-008 SHALL have port in_valid, input, 1, meaning rename offers an instruction.
REQ-009 SHALL have port in_ready, output, 1, meaning router accepts the instruction this cycle.
REQ-010 SHALL have port in_fu, input, 2, meaning fu_type_t encoding: 0 ALU, 1 LSU, 2 BRANCH, 3 OTHER.
REQ-011 SHALL have port in_data, input, DATA_W, meaning payload.
REQ-012 SHALL have ports alu_valid, lsu_valid, br_valid, other_valid, output, 1 each, meaning issue strobe to that destination.
REQ-013 SHALL have port out_data, output, DATA_W, meaning payload shared by all destinations.
REQ-014 SHALL have ports alu_cred_ret, lsu_cred_ret, br_cred_ret, input, 1 each, meaning the station freed one entry.
REQ-015 SHALL have port stall_cnt, output, 16, meaning cycles the holding register was valid but blocked.

Function
REQ-016 SHALL contain one holding register (hold_v, hold_fu, hold_data); out_data SHALL equal hold_data.
REQ-017 SHALL keep credit counters alu_c, lsu_c, br_c, each sized to represent 0..its max.
REQ-018 SHALL assert alu_valid = hold_v & hold_fu==0 & alu_c!=0; lsu_valid and br_valid analogously; other_valid = hold_v & hold_fu==3 with no credit check.
REQ-019 SHALL define issue = any *_valid asserted; at most one *_valid SHALL be high per cycle.
REQ-020 SHALL drive in_ready = !flush & (!hold_v | issue), giving full throughput: one instruction per cycle when credits allow.
REQ-021 SHALL load the holding register on in_valid & in_ready; it SHALL clear hold_v on issue without a new load.
REQ-022 SHALL decrement a counter on its issue, increment on its cred_ret, and leave it unchanged when both occur in the same cycle.
REQ-023 SHALL ignore cred_ret that would exceed the max, never wrap, and flag it with a simulation assertion.
REQ-024 SHALL block an instruction whose credit is 0, holding hold_data stable and deasserting in_ready until a cred_ret arrives; the held instruction SHALL issue in the cycle after that return.
REQ-025 SHALL, on flush, clear hold_v, set all credits to max at the next edge, suppress all *_valid in the flush cycle, and deassert in_ready.
REQ-026 SHALL increment stall_cnt each cycle with hold_v & !issue & !flush, saturating at 16'hFFFF; flush SHALL NOT clear it.

Reset
REQ-027 SHALL, while rst_n is low, force hold_v=0, all *_valid=0, in_ready=0, stall_cnt=0, alu_c=ALU_CRED, lsu_c=LSU_CRED, br_c=BR_CRED, regardless of clk.
REQ-028 SHALL assert in_ready in the first cycle after rst_n deasserts; hold_data SHALL be don't-care during reset.

Verification
REQ-029 Back-to-back: 8 ALU ops with in_valid held high -> alu_valid for 8 consecutive cycles starting 1 cycle after the first accept; alu_c reaches 0.
REQ-030 Credit exhaustion: 5 BR ops, no returns -> 4 issue; the 5th holds, in_ready=0, and stall_cnt increments each cycle; one br_cred_ret -> 5th issues on the next cycle.
REQ-031 Simultaneous: with alu_c=3, issue ALU and alu_cred_ret in the same cycle -> alu_c stays 3.
REQ-032 Flush mid-stall: blocked LSU op with lsu_c=0, assert flush -> no lsu_valid, hold_v=0 and lsu_c=8 next cycle, in_ready=1 after flush drops.
REQ-033 OTHER routing: in_fu=3 with all credits 0 -> other_valid pulses 1 cycle after accept and credits are unchanged.
REQ-034 Async reset: drop rst_n between clock edges during traffic -> all outputs are at reset values immediately, before the next edge.
